bus_arbiter_mem: RTL and testbench

- Responder end of the core bus handshake (grant_request / grant_given / rw / address / data).
- Arbitrates up to NUM_CORES requesters round-robin and performs the single-byte access against an internal byte-wide memory.
- Returns read data and a one-cycle grant pulse to the winning core.
- Sits between the cores and program/data memory at the top level.

---
 rtl/bus_arbiter_mem_if.sv | 29 ++
 rtl/bus_arbiter_mem.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter_mem.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_mem_if.sv
// Core-side bus bundle for bus_arbiter_mem: per-core request/operand vectors in,
// one-hot grant pulse, broadcast read data and busy out.
interface bus_arbiter_mem_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8
);
    // Handshake: a core raises grant_request[i] with rw/address/data_out stable and
    // holds it until it sees grant_given[i] high for one cycle; data_in is valid in
    // that same cycle for reads. Operands are captured when the request is accepted.
    logic [NUM_CORES-1:0]        grant_request;
    logic [NUM_CORES-1:0]        rw;
    logic [NUM_CORES*ADDR_W-1:0] address;
    logic [NUM_CORES*DATA_W-1:0] data_out;
    logic [NUM_CORES-1:0]        grant_given;
    logic [DATA_W-1:0]           data_in;
    logic                        busy;
    logic [1:0]                  dbg_state;

    modport master (
        output grant_request, rw, address, data_out,
        input  grant_given, data_in, busy, dbg_state
    );

    modport slave (
        input  grant_request, rw, address, data_out,
        output grant_given, data_in, busy, dbg_state
    );
endinterface

// File: rtl/bus_arbiter_mem.sv
// Round-robin arbiter in front of a byte-wide memory: one single-byte access per
// transaction, IDLE -> ACCESS -> GRANT -> RECOVER, grant pulsed to the winner.
module bus_arbiter_mem #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_arbiter_mem_if.slave     bus
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        GRANT   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic                   lat_rw_q, lat_rw_d;
    logic [ADDR_W-1:0]      lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]      lat_wdata_q, lat_wdata_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0]      data_in_q, data_in_d;
    logic                   busy_q, busy_d;

    logic [DATA_W-1:0]      mem [DEPTH];

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W:0]         sum;
    logic                   sel_rw;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;

    // Scan from the pointer, wrapping, and take the first requesting core.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        sum        = '0;
        sel_rw     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_CORES)) begin
                sum = sum - (IDX_W+1)'(NUM_CORES);
            end
            cand = sum[IDX_W-1:0];
            if (!pick_valid && bus.grant_request[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_rw    = bus.rw[i];
                sel_addr  = bus.address[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.data_out[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        lat_rw_d    = lat_rw_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        grant_d     = '0;
        data_in_d   = data_in_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ACCESS;
                    win_d       = pick_idx;
                    lat_rw_d    = sel_rw;
                    lat_addr_d  = sel_addr;
                    lat_wdata_d = sel_wdata;
                end
            end
            ACCESS: begin
                state_d = GRANT;
                if (!lat_rw_q) begin
                    data_in_d = mem[lat_addr_q];
                end
                grant_d[win_q] = 1'b1;
            end
            GRANT: begin
                state_d = RECOVER;
                ptr_d   = (win_q == IDX_W'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            lat_rw_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            grant_q     <= '0;
            data_in_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            lat_rw_q    <= lat_rw_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            grant_q     <= grant_d;
            data_in_q   <= data_in_d;
            busy_q      <= busy_d;
        end
    end

    // Memory keeps its contents across reset; a reset before the ACCESS exit edge
    // has already forced the state back to IDLE, so the write never lands.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && lat_rw_q) begin
            mem[lat_addr_q] <= lat_wdata_q;
        end
    end

    assign bus.grant_given = grant_q;
    assign bus.data_in     = data_in_q;
    assign bus.busy        = busy_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_bus_arbiter_mem.sv
// Directed bench for bus_arbiter_mem: transaction-level reference model checked
// every cycle, plus literal expectations for latency, data and grant order.
module tb_bus_arbiter_mem;
    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_mem_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter_mem #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction = request accepted, memory access,
    // grant cycle, recovery cycle; phase counts through those four steps.
    logic [DW-1:0] mm [int];
    int            m_phase = 0;
    int            m_ptr   = 0;
    int            m_win   = 0;
    logic          m_rw    = 1'b0;
    int            m_addr  = 0;
    logic [DW-1:0] m_wd    = '0;
    logic [DW-1:0] m_data  = '0;
    bit            m_known = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_ptr   = 0;
            m_data  = '0;
            m_known = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    bit found;
                    int c;
                    found = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        c = (m_ptr + i) % N;
                        if (!found && bus.grant_request[c]) begin
                            found   = 1'b1;
                            m_win   = c;
                            m_rw    = bus.rw[c];
                            m_addr  = int'(bus.address[c*AW +: AW]);
                            m_wd    = bus.data_out[c*DW +: DW];
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (m_rw) begin
                        mm[m_addr] = m_wd;
                    end else if (mm.exists(m_addr)) begin
                        m_data  = mm[m_addr];
                        m_known = 1'b1;
                    end else begin
                        m_known = 1'b0;
                    end
                    m_phase = 2;
                end
                2: begin
                    m_ptr   = (m_win + 1) % N;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    int            gl_core [$];
    int            gl_cyc  [$];
    logic [DW-1:0] gl_data [$];

    always @(negedge clk) begin
        if (reset) begin
            logic [N-1:0] eg;
            eg = '0;
            if (m_phase == 2) eg[m_win] = 1'b1;
            check("grant_given", 32'(bus.grant_given), 32'(eg));
            check("busy", 32'(bus.busy), 32'(m_phase != 0));
            check("grant_onehot", 32'($countones(bus.grant_given) <= 1), 32'd1);
            if (m_known) check("data_in", 32'(bus.data_in), 32'(m_data));
            for (int i = 0; i < N; i++) begin
                if (bus.grant_given[i]) begin
                    gl_core.push_back(i);
                    gl_cyc.push_back(cyc);
                    gl_data.push_back(bus.data_in);
                end
            end
        end
    end

    task automatic set_req(input int core, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.rw[core]                = w;
        bus.address[core*AW +: AW]  = a;
        bus.data_out[core*DW +: DW] = d;
        bus.grant_request[core]     = 1'b1;
    endtask

    task automatic wait_grant(input int core, output int gcyc, output logic [DW-1:0] gdata);
        bit got;
        got   = 1'b0;
        gcyc  = -1;
        gdata = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.grant_given[core]) begin
                got   = 1'b1;
                gcyc  = cyc;
                gdata = bus.data_in;
                bus.grant_request[core] = 1'b0;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL grant_timeout: core %0d got no grant, required one within 40 cycles", core);
            bus.grant_request[core] = 1'b0;
        end
    endtask

    // Called on a negedge while the arbiter is idle; returns on an idle negedge.
    task automatic xact(input int core, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
        int c;
        int g;
        c = cyc;
        set_req(core, w, a, d);
        wait_grant(core, g, rd);
        lat = g - c;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            c;
        int            g;
        logic [DW-1:0] rd;

        bus.grant_request = '0;
        bus.rw            = '0;
        bus.address       = '0;
        bus.data_out      = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant_given), 32'd0);
        check("rst_data_in", 32'(bus.data_in), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write then read through core 0.
        xact(0, 1'b1, 10'h003, 8'hA5, lat, rd);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_data_in_unchanged", 32'(rd), 32'h00);
        xact(0, 1'b0, 10'h003, 8'h00, lat, rd);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_data", 32'(rd), 32'hA5);

        // Preload, then reset to show memory survives and the pointer returns to 0.
        xact(0, 1'b1, 10'h010, 8'h11, lat, rd);
        xact(1, 1'b1, 10'h020, 8'h22, lat, rd);
        xact(0, 1'b1, 10'h040, 8'h77, lat, rd);
        xact(1, 1'b1, 10'h041, 8'h88, lat, rd);
        xact(0, 1'b1, 10'h050, 8'h3C, lat, rd);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Contention from reset.
        c = cyc;
        set_req(0, 1'b0, 10'h010, 8'h00);
        set_req(1, 1'b0, 10'h020, 8'h00);
        wait_grant(0, g, rd);
        check("cont_c0_latency", 32'(g - c), 32'd2);
        check("cont_c0_data", 32'(rd), 32'h11);
        c = g;
        wait_grant(1, g, rd);
        check("cont_c1_spacing", 32'(g - c), 32'd4);
        check("cont_c1_data", 32'(rd), 32'h22);
        repeat (2) @(negedge clk);

        // Both cores hold requests for 8 transactions.
        gl_core.delete();
        gl_cyc.delete();
        gl_data.delete();
        set_req(0, 1'b0, 10'h010, 8'h00);
        set_req(1, 1'b0, 10'h020, 8'h00);
        for (int n = 0; n < 80 && gl_core.size() < 8; n++) @(negedge clk);
        bus.grant_request = '0;
        check("rr_count", 32'(gl_core.size()), 32'd8);
        for (int i = 0; i < gl_core.size() && i < 8; i++) begin
            check("rr_order", 32'(gl_core[i]), 32'(i % 2));
            check("rr_data", 32'(gl_data[i]), (i % 2) ? 32'h22 : 32'h11);
            if (i > 0) check("rr_spacing", 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd4);
        end
        repeat (3) @(negedge clk);

        // Address changes after the request has been accepted.
        c = cyc;
        set_req(1, 1'b0, 10'h040, 8'h00);
        @(negedge clk);
        bus.address[AW +: AW] = 10'h041;
        wait_grant(1, g, rd);
        check("latch_latency", 32'(g - c), 32'd2);
        check("latch_data", 32'(rd), 32'h77);
        repeat (2) @(negedge clk);

        // Reset during ACCESS of a write.
        set_req(0, 1'b1, 10'h050, 8'hFF);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstacc_busy", 32'(bus.busy), 32'd0);
        check("rstacc_grant", 32'(bus.grant_given), 32'd0);
        check("rstacc_data_in", 32'(bus.data_in), 32'd0);
        bus.grant_request = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 10'h050, 8'h00, lat, rd);
        check("rstacc_readback", 32'(rd), 32'h3C);

        // Reset while the grant is high.
        set_req(1, 1'b0, 10'h041, 8'h00);
        wait_grant(1, g, rd);
        check("rstgnt_data", 32'(rd), 32'h88);
        #2 reset = 1'b0;
        #1;
        check("rstgnt_grant", 32'(bus.grant_given), 32'd0);
        check("rstgnt_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 10'h050, 8'h00, lat, rd);
        check("post_rst_read", 32'(rd), 32'h3C);

        // Idle stretch.
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_grant", 32'(bus.grant_given), 32'd0);
        check("idle_data_in", 32'(bus.data_in), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
